// File: rtl/fetch_pfq.sv
// Instruction fetch unit feeding a first-word-fall-through prefetch queue toward ID.
// Optional macro FETCH_JAL_PREDICT_EN: follow JAL targets at push time instead of PC+4.
module fetch_pfq #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] PC_RESET = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [31:0]     imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [31:0]     id_instr_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic            id_exc_o
);
    localparam int          PW       = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef enum logic {FETCH, HALT} state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_fpc;
    logic [PW:0]     r_count;
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [XLEN-1:0] r_pc_q    [DEPTH];
    logic [31:0]     r_instr_q [DEPTH];
    logic [DEPTH-1:0] r_exc_q;

    logic            w_try;
    logic            w_aligned;
    logic            w_mem_push;
    logic            w_exc_push;
    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_next_pc;

    // Requests are suppressed combinationally during reset and redirect.
    assign w_try       = rst_n && (r_state == FETCH) && (r_count != CNT_FULL) && !redirect_i;
    assign w_aligned   = (r_fpc[1:0] == 2'b00);
    assign imem_req_o  = w_try && w_aligned;
    assign imem_addr_o = r_fpc;
    assign w_mem_push  = imem_req_o && imem_ack_i;
    assign w_exc_push  = w_try && !w_aligned;
    assign w_push      = w_mem_push || w_exc_push;

    assign id_valid_o  = rst_n && (r_count != '0);
    assign w_pop       = id_valid_o && id_ready_i && !redirect_i;
    assign id_instr_o  = r_instr_q[r_rptr];
    assign id_pc_o     = r_pc_q[r_rptr];
    assign id_exc_o    = r_exc_q[r_rptr];

`ifdef FETCH_JAL_PREDICT_EN
    logic [XLEN-1:0] w_jimm;
    assign w_jimm    = {{(XLEN-20){imem_rdata_i[31]}}, imem_rdata_i[19:12], imem_rdata_i[20],
                        imem_rdata_i[30:21], 1'b0};
    assign w_next_pc = (imem_rdata_i[6:0] == 7'b1101111) ? r_fpc + w_jimm : r_fpc + XLEN'(4);
`else
    assign w_next_pc = r_fpc + XLEN'(4);
`endif

    // Queue payload needs no reset: it is never observed while count is zero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_q[r_wptr]    <= r_fpc;
            r_instr_q[r_wptr] <= w_mem_push ? imem_rdata_i : NOP;
            r_exc_q[r_wptr]   <= w_exc_push;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= FETCH;
            r_fpc   <= PC_RESET;
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else if (redirect_i) begin
            r_state <= FETCH;
            r_fpc   <= redirect_pc_i;
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + PW'(1);
            if (w_pop)
                r_rptr <= r_rptr + PW'(1);
            if (w_mem_push)
                r_fpc <= w_next_pc;
            // A misaligned PC yields one poisoned entry and parks fetch until redirect.
            if (w_exc_push)
                r_state <= HALT;
            r_count <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
        end
    end
endmodule

// File: doc/fetch_pfq.md
FETCH_PFQ -- requirements
Module: fetch_pfq

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning PC/address width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning prefetch queue entries; legal values are powers of two from 2 to 16.
REQ-003 SHALL have parameter PC_RESET, default 32'h0000_0000, meaning fetch PC after reset.
REQ-004 SHALL have port clk, input, 1, clock.
REQ-005 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-006 SHALL have port imem_req_o, output, 1, instruction memory request.
REQ-007 SHALL have port imem_addr_o, output, XLEN, request address.
REQ-008 SHALL have port imem_ack_i, input, 1, response valid; legal only while imem_req_o=1.
REQ-009 SHALL have port imem_rdata_i, input, 32, instruction word, valid with imem_ack_i.
REQ-010 SHALL have port redirect_i, input, 1, flush and redirect request (from EXE/CSR, pre-merged).
REQ-011 SHALL have port redirect_pc_i, input, XLEN, redirect target.
REQ-012 SHALL have port id_valid_o, output, 1, queue head valid.
REQ-013 SHALL have port id_ready_i, input, 1, ID accepts head.
REQ-014 SHALL have port id_instr_o, output, 32, head instruction.
REQ-015 SHALL have port id_pc_o, output, XLEN, head PC.
REQ-016 SHALL have port id_exc_o, output, 1, head carries instruction-address-misaligned exception.

Function
REQ-017 SHALL hold fetch PC (fpc), a count (0..DEPTH) and a halt flag, and run FSM states FETCH, HALT.
REQ-018 SHALL drive imem_req_o=1, imem_addr_o=fpc in FETCH when count<DEPTH, fpc[1:0]==0 and redirect_i=0; otherwise imem_req_o=0.
REQ-019 SHALL hold imem_addr_o stable while imem_req_o=1 until imem_ack_i; same-cycle ack SHALL be accepted (one outstanding request maximum).
REQ-020 SHALL, on accepted ack, push {fpc, imem_rdata_i, exc=0} at tail and set fpc=fpc+4 (wrapping modulo 2^XLEN).
REQ-021 SHALL, in FETCH with fpc[1:0]!=0, count<DEPTH and no redirect, push {fpc, 32'h0000_0013, exc=1} with no memory request and enter HALT.
REQ-022 SHALL in HALT issue no requests and push nothing until redirect_i.
REQ-023 SHALL present the head combinationally (first-word-fall-through): id_valid_o=(count>0); pop when id_valid_o&id_ready_i.
REQ-024 SHALL support push and pop in the same cycle with count unchanged; push never occurs at count==DEPTH.
REQ-025 SHALL, on redirect_i=1, flush all entries (count=0), set fpc=redirect_pc_i, enter FETCH, force imem_req_o=0 and ignore imem_ack_i and id_ready_i that cycle.
REQ-026 SHALL issue the request to redirect_pc_i in the cycle after redirect; with immediate ack, id_valid_o=1 two cycles after redirect.
REQ-027 SHALL use read/write pointers of log2(DEPTH) bits, wrapping naturally; the queue is full when count==DEPTH and empty when count==0.

Reset
REQ-028 SHALL on rst_n=0 at clk edge set fpc=PC_RESET, count=0, pointers=0, state=FETCH.
REQ-029 SHALL output imem_req_o=0 and id_valid_o=0 while rst_n=0; reset mid-request SHALL abandon it; queue contents SHALL be don't-care when count=0.

Configuration
REQ-030 SHALL, with FETCH_JAL_PREDICT_EN defined, on a push whose instruction has opcode[6:0]=7'b1101111, set fpc=pushed PC+sign-extended J-immediate instead of +4.
REQ-031 SHALL, without FETCH_JAL_PREDICT_EN, always advance fpc by 4 on a push; JAL resolution is by redirect only.

Verification
REQ-032 Reset, mem always acks, id_ready=0 -> requests at 0x0,0x4,0x8,0xC; count=4; imem_req_o=0 thereafter.
REQ-033 Full queue, then id_ready=1 for 1 cycle -> head 0x0 popped; next request to 0x10 in the following cycle.
REQ-034 Outstanding request to 0x8 with ack delayed; redirect to 0x100 -> queue empty, late ack ignored, next request to 0x100, id_pc_o=0x100.
REQ-035 Redirect to 0x102 -> single entry pc=0x102, id_exc_o=1, instr=0x00000013; no imem_req_o until next redirect.
REQ-036 FETCH_JAL_PREDICT_EN defined, word 0x0100006F at 0x20 -> next request 0x30; undefined -> 0x24.
REQ-037 rst_n=0 mid-stream with count=3 -> id_valid_o=0 next cycle, first request afterwards to PC_RESET.
